// File: rtl/facache_n.sv
// rtl/facache_n.sv - parametrised fully-associative cache with true-LRU replacement
// Optional hit/miss statistics are built when FACACHE_N_STATS_EN is defined.
module facache_n #(
  parameter  int ADR_W   = 16,
  parameter  int DATA_W  = 16,
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  output logic              rd_miss,
  input  logic              ins_valid,
  input  logic [ADR_W-1:0]  ins_adr,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              inv_en,
  input  logic [ADR_W-1:0]  inv_adr,
  output logic              ev_valid,
  output logic [ADR_W-1:0]  ev_adr,
  output logic [DATA_W-1:0] ev_data,
  output logic [IDX_W:0]    occupancy,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam logic [IDX_W-1:0] AGE_LRU = IDX_W'(ENTRIES - 1);

  logic              r_v    [ENTRIES];
  logic [ADR_W-1:0]  r_tag  [ENTRIES];
  logic [DATA_W-1:0] r_data [ENTRIES];
  logic [IDX_W-1:0]  r_age  [ENTRIES];

  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_hit, r_rd_miss, r_ev_valid;
  logic [ADR_W-1:0]  r_ev_adr;
  logic [DATA_W-1:0] r_ev_data;
  logic [IDX_W:0]    r_occ;

  logic             w_rd_found, w_ins_found, w_inv_found, w_free_found;
  logic [IDX_W-1:0] w_rd_idx, w_ins_idx, w_inv_idx, w_free_idx, w_lru_idx;
  logic             w_inv_do, w_ins_do, w_fill, w_evict, w_touch_en;
  logic [IDX_W-1:0] w_ins_sel, w_touch_idx, w_touch_age, w_inv_age;

  // All lookups see the state as it stood at the start of the cycle.
  always_comb begin
    w_rd_found   = 1'b0;
    w_ins_found  = 1'b0;
    w_inv_found  = 1'b0;
    w_free_found = 1'b0;
    w_rd_idx     = '0;
    w_ins_idx    = '0;
    w_inv_idx    = '0;
    w_free_idx   = '0;
    w_lru_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_v[i] && r_tag[i] == rd_adr) begin
        w_rd_found = 1'b1;
        w_rd_idx   = IDX_W'(i);
      end
      if (r_v[i] && r_tag[i] == ins_adr) begin
        w_ins_found = 1'b1;
        w_ins_idx   = IDX_W'(i);
      end
      if (r_v[i] && r_tag[i] == inv_adr) begin
        w_inv_found = 1'b1;
        w_inv_idx   = IDX_W'(i);
      end
      if (r_age[i] == AGE_LRU) w_lru_idx = IDX_W'(i);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_v[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Invalidate wins over insert; an insert touch wins over a read-hit touch.
  always_comb begin
    w_inv_do    = inv_en && w_inv_found;
    w_ins_do    = ins_valid && !inv_en;
    w_fill      = w_ins_do && !w_ins_found && w_free_found;
    w_evict     = w_ins_do && !w_ins_found && !w_free_found;
    w_ins_sel   = w_ins_found ? w_ins_idx : (w_free_found ? w_free_idx : w_lru_idx);
    w_touch_en  = w_ins_do || (!w_inv_do && rd_en && w_rd_found);
    w_touch_idx = w_ins_do ? w_ins_sel : w_rd_idx;
    w_touch_age = r_age[w_touch_idx];
    w_inv_age   = r_age[w_inv_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_v[i]    <= 1'b0;
        r_tag[i]  <= '0;
        r_data[i] <= '0;
        r_age[i]  <= IDX_W'(i);
      end
      r_rd_data  <= '0;
      r_rd_hit   <= 1'b0;
      r_rd_miss  <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_adr   <= '0;
      r_ev_data  <= '0;
      r_occ      <= '0;
    end else begin
      r_rd_hit  <= rd_en && w_rd_found;
      r_rd_miss <= rd_en && !w_rd_found;
      if (rd_en) r_rd_data <= w_rd_found ? r_data[w_rd_idx] : '0;

      r_ev_valid <= w_evict;
      if (w_evict) begin
        r_ev_adr  <= r_tag[w_ins_sel];
        r_ev_data <= r_data[w_ins_sel];
      end

      if (w_ins_do) begin
        r_v[w_ins_sel]    <= 1'b1;
        r_tag[w_ins_sel]  <= ins_adr;
        r_data[w_ins_sel] <= ins_data;
      end
      if (w_inv_do) r_v[w_inv_idx] <= 1'b0;

      for (int i = 0; i < ENTRIES; i++) begin
        if (w_inv_do) begin
          if (IDX_W'(i) == w_inv_idx) r_age[i] <= AGE_LRU;
          else if (r_age[i] > w_inv_age) r_age[i] <= r_age[i] - IDX_W'(1);
        end else if (w_touch_en) begin
          if (IDX_W'(i) == w_touch_idx) r_age[i] <= '0;
          else if (r_age[i] < w_touch_age) r_age[i] <= r_age[i] + IDX_W'(1);
        end
      end

      if (w_fill) r_occ <= r_occ + (IDX_W+1)'(1);
      else if (w_inv_do) r_occ <= r_occ - (IDX_W+1)'(1);
    end
  end

`ifdef FACACHE_N_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rd_en) begin
      if (w_rd_found && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (!w_rd_found && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

  assign rd_data   = r_rd_data;
  assign rd_hit    = r_rd_hit;
  assign rd_miss   = r_rd_miss;
  assign ev_valid  = r_ev_valid;
  assign ev_adr    = r_ev_adr;
  assign ev_data   = r_ev_data;
  assign occupancy = r_occ;
endmodule

// File: tb/tb_facache_n.sv
// tb/tb_facache_n.sv - self-checking bench for facache_n against a recency-list model
module tb_facache_n;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, ins_valid = 1'b0, inv_en = 1'b0;
  logic [15:0] rd_adr = '0, ins_adr = '0, ins_data = '0, inv_adr = '0;
  logic [15:0] rd_data, ev_adr, ev_data, hit_count, miss_count;
  logic        rd_hit, rd_miss, ev_valid;
  logic [2:0]  occupancy;

  facache_n dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .rd_hit(rd_hit), .rd_miss(rd_miss),
    .ins_valid(ins_valid), .ins_adr(ins_adr), .ins_data(ins_data),
    .inv_en(inv_en), .inv_adr(inv_adr),
    .ev_valid(ev_valid), .ev_adr(ev_adr), .ev_data(ev_data),
    .occupancy(occupancy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: line contents plus a recency list, most recent first.
  bit          m_v    [N];
  logic [15:0] m_tag  [N];
  logic [15:0] m_data [N];
  int          lru_q  [$];
  bit          e_hit, e_miss, e_evv;
  logic [15:0] e_data, e_eva, e_evd;
  int          e_occ, e_hc, e_mc;

  function automatic int find(input logic [15:0] a);
    int r = -1;
    for (int j = 0; j < N; j++) if (m_v[j] && m_tag[j] == a) r = j;
    return r;
  endfunction

  task automatic lru_remove(input int j);
    for (int k = 0; k < lru_q.size(); k++) begin
      if (lru_q[k] == j) begin
        lru_q.delete(k);
        break;
      end
    end
  endtask

  task automatic touch(input int j);
    lru_remove(j);
    lru_q.push_front(j);
  endtask

  task automatic model_reset();
    lru_q = {};
    for (int j = 0; j < N; j++) begin
      m_v[j] = 0; m_tag[j] = '0; m_data[j] = '0;
      lru_q.push_back(j);
    end
    e_hit = 0; e_miss = 0; e_evv = 0; e_data = '0; e_eva = '0; e_evd = '0;
    e_occ = 0; e_hc = 0; e_mc = 0;
  endtask

  task automatic model(input bit re, input logic [15:0] ra, input bit iv, input logic [15:0] ia,
                       input logic [15:0] id, input bit ie, input logic [15:0] iva);
    int rj, ij, vj, fj, tgt;
    rj = find(ra); ij = find(ia); vj = find(iva);
    e_hit = re && rj >= 0;
    e_miss = re && rj < 0;
    if (re) e_data = (rj >= 0) ? m_data[rj] : 16'h0;
`ifdef FACACHE_N_STATS_EN
    if (e_hit && e_hc < 65535) e_hc++;
    if (e_miss && e_mc < 65535) e_mc++;
`endif
    e_evv = 0;
    if (ie && vj >= 0) begin
      m_v[vj] = 0;
      e_occ--;
      lru_remove(vj);
      lru_q.push_back(vj);
    end else if (iv && !ie) begin
      if (ij >= 0) begin
        m_data[ij] = id;
        touch(ij);
      end else begin
        fj = -1;
        for (int j = N - 1; j >= 0; j--) if (!m_v[j]) fj = j;
        if (fj >= 0) begin
          tgt = fj;
          e_occ++;
        end else begin
          tgt = lru_q[lru_q.size() - 1];
          e_evv = 1; e_eva = m_tag[tgt]; e_evd = m_data[tgt];
        end
        m_v[tgt] = 1; m_tag[tgt] = ia; m_data[tgt] = id;
        touch(tgt);
      end
    end else if (re && rj >= 0) begin
      touch(rj);
    end
  endtask

  task automatic step(input bit re, input logic [15:0] ra, input bit iv, input logic [15:0] ia,
                      input logic [15:0] id, input bit ie, input logic [15:0] iva);
    rd_en = re; rd_adr = ra; ins_valid = iv; ins_adr = ia; ins_data = id; inv_en = ie; inv_adr = iva;
    model(re, ra, iv, ia, id, ie, iva);
    @(posedge clk);
    #1;
    rd_en = 0; ins_valid = 0; inv_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rd_hit !== 1'b0 || rd_miss !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got hit=%b miss=%b expected 0 0", rd_hit, rd_miss); end
    n_checks++; if (rd_data !== 16'h0) begin n_errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    n_checks++; if (ev_valid !== 1'b0 || ev_adr !== 16'h0 || ev_data !== 16'h0) begin n_errors++; $display("FAIL reset_ev: got %b %h %h expected 0 0000 0000", ev_valid, ev_adr, ev_data); end
    n_checks++; if (occupancy !== 3'd0 || hit_count !== 16'h0 || miss_count !== 16'h0) begin n_errors++; $display("FAIL reset_occ_cnt: got %0d %0d %0d expected 0 0 0", occupancy, hit_count, miss_count); end
  endtask

  task automatic test_fill_and_evict();
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 16'h0A00 + 16'(k), 16'hD000 + 16'(k), 0, 0);
      n_checks++; if (ev_valid !== 1'b0) begin n_errors++; $display("FAIL fill_no_ev%0d: got %b expected 0", k, ev_valid); end
    end
    n_checks++; if (occupancy !== 3'd4) begin n_errors++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
    step(1, 16'h0A01, 0, 0, 0, 0, 0);
    n_checks++; if (rd_hit !== 1'b1 || rd_data !== 16'hD001) begin n_errors++; $display("FAIL read_a1: got hit=%b data=%h expected 1 d001", rd_hit, rd_data); end
    step(0, 0, 1, 16'h0A04, 16'hD004, 0, 0);
    n_checks++; if (ev_valid !== 1'b1 || ev_adr !== 16'h0A00 || ev_data !== 16'hD000) begin n_errors++; $display("FAIL evict_a0: got %b %h %h expected 1 0a00 d000", ev_valid, ev_adr, ev_data); end
    step(1, 16'h0A00, 0, 0, 0, 0, 0);
    n_checks++; if (rd_miss !== 1'b1 || rd_data !== 16'h0 || ev_valid !== 1'b0) begin n_errors++; $display("FAIL read_a0_miss: got miss=%b data=%h ev=%b expected 1 0000 0", rd_miss, rd_data, ev_valid); end
    n_checks++; if (ev_adr !== 16'h0A00 || ev_data !== 16'hD000) begin n_errors++; $display("FAIL ev_hold: got %h %h expected 0a00 d000", ev_adr, ev_data); end
  endtask

  task automatic test_update_invalidate();
    step(0, 0, 1, 16'h0A02, 16'h1234, 0, 0);
    n_checks++; if (ev_valid !== 1'b0 || occupancy !== 3'd4) begin n_errors++; $display("FAIL update: got ev=%b occ=%0d expected 0 4", ev_valid, occupancy); end
    step(1, 16'h0A02, 0, 0, 0, 0, 0);
    n_checks++; if (rd_hit !== 1'b1 || rd_data !== 16'h1234) begin n_errors++; $display("FAIL read_update: got %b %h expected 1 1234", rd_hit, rd_data); end
    step(0, 0, 0, 0, 0, 1, 16'h0A03);
    n_checks++; if (occupancy !== 3'd3 || ev_valid !== 1'b0) begin n_errors++; $display("FAIL inv_a3: got occ=%0d ev=%b expected 3 0", occupancy, ev_valid); end
    step(0, 0, 1, 16'h0A05, 16'hD005, 0, 0);
    n_checks++; if (occupancy !== 3'd4 || ev_valid !== 1'b0) begin n_errors++; $display("FAIL refill_a5: got occ=%0d ev=%b expected 4 0", occupancy, ev_valid); end
    step(1, 16'h0A05, 0, 0, 0, 1, 16'h0A07);
    n_checks++; if (rd_hit !== 1'b1 || rd_data !== 16'hD005 || occupancy !== 3'd4) begin n_errors++; $display("FAIL inv_absent: got %b %h %0d expected 1 d005 4", rd_hit, rd_data, occupancy); end
  endtask

  task automatic test_same_cycle();
    step(1, 16'h0A06, 1, 16'h0A06, 16'hD006, 0, 0);
    n_checks++; if (rd_miss !== 1'b1 || rd_hit !== 1'b0) begin n_errors++; $display("FAIL rd_ins_same: got miss=%b hit=%b expected 1 0", rd_miss, rd_hit); end
    n_checks++; if (ev_valid !== 1'b1 || ev_adr !== 16'h0A01 || ev_data !== 16'hD001) begin n_errors++; $display("FAIL rd_ins_evict: got %b %h %h expected 1 0a01 d001", ev_valid, ev_adr, ev_data); end
    step(1, 16'h0A06, 0, 0, 0, 0, 0);
    n_checks++; if (rd_hit !== 1'b1 || rd_data !== 16'hD006) begin n_errors++; $display("FAIL read_a6: got %b %h expected 1 d006", rd_hit, rd_data); end
    step(0, 0, 1, 16'h0A07, 16'hD007, 1, 16'h0A02);
    n_checks++; if (occupancy !== 3'd3 || ev_valid !== 1'b0) begin n_errors++; $display("FAIL inv_ins_same: got occ=%0d ev=%b expected 3 0", occupancy, ev_valid); end
    step(1, 16'h0A07, 0, 0, 0, 0, 0);
    n_checks++; if (rd_miss !== 1'b1) begin n_errors++; $display("FAIL ins_dropped: got miss=%b expected 1", rd_miss); end
  endtask

  task automatic test_random();
    bit          re, iv, ie;
    logic [15:0] ra, ia, id, iva;
    int          errs = 0;
    for (int c = 0; c < 600; c++) begin
      ie  = ($urandom_range(0, 99) < 15);
      iv  = ($urandom_range(0, 1) == 1);
      re  = ie ? 1'b0 : ($urandom_range(0, 2) != 0);
      ra  = 16'h0B00 + 16'($urandom_range(0, 6));
      ia  = 16'h0B00 + 16'($urandom_range(0, 6));
      iva = 16'h0B00 + 16'($urandom_range(0, 6));
      id  = 16'($urandom);
      step(re, ra, iv, ia, id, ie, iva);
      n_checks++;
      if (rd_hit !== e_hit || rd_miss !== e_miss || rd_data !== e_data || ev_valid !== e_evv ||
          ev_adr !== e_eva || ev_data !== e_evd || occupancy !== 3'(e_occ) ||
          hit_count !== 16'(e_hc) || miss_count !== 16'(e_mc)) begin
        n_errors++;
        errs++;
        if (errs < 10)
          $display("FAIL random_c%0d: got %b%b %h %b %h %h %0d %0d %0d expected %b%b %h %b %h %h %0d %0d %0d",
                   c, rd_hit, rd_miss, rd_data, ev_valid, ev_adr, ev_data, occupancy, hit_count, miss_count,
                   e_hit, e_miss, e_data, e_evv, e_eva, e_evd, e_occ, e_hc, e_mc);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 0, 1, 16'h0C00 + 16'(k), 16'hBE00 + 16'(k), 0, 0);
    step(1, 16'h0C02, 1, 16'h0C09, 16'h5555, 0, 0);
    n_checks++; if (rd_hit !== 1'b1 || ev_valid !== 1'b1 || rd_data !== 16'hBE02) begin n_errors++; $display("FAIL pre_rst: got %b %b %h expected 1 1 be02", rd_hit, ev_valid, rd_data); end
    #3 rst = 1;
    #1;
    n_checks++; if (rd_hit !== 1'b0 || rd_miss !== 1'b0 || rd_data !== 16'h0 || ev_valid !== 1'b0 || ev_adr !== 16'h0 || ev_data !== 16'h0 || occupancy !== 3'd0) begin
      n_errors++; $display("FAIL async_rst: got %b %b %h %b %h %h %0d expected all 0", rd_hit, rd_miss, rd_data, ev_valid, ev_adr, ev_data, occupancy); end
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 16'h0C00 + 16'(k), 0, 0, 0, 0, 0);
      n_checks++; if (rd_miss !== 1'b1 || rd_hit !== 1'b0) begin n_errors++; $display("FAIL post_rst_miss%0d: got miss=%b hit=%b expected 1 0", k, rd_miss, rd_hit); end
    end
  endtask

  task automatic test_stats();
    do_reset();
    step(0, 0, 1, 16'h0D00, 16'h7777, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 16'h0D00, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) step(1, 16'h0D01, 0, 0, 0, 0, 0);
`ifdef FACACHE_N_STATS_EN
    n_checks++; if (hit_count !== 16'd3 || miss_count !== 16'd2) begin n_errors++; $display("FAIL stats: got %0d %0d expected 3 2", hit_count, miss_count); end
`else
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_errors++; $display("FAIL stats_off: got %0d %0d expected 0 0", hit_count, miss_count); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_and_evict();
    test_update_invalidate();
    test_same_cycle();
    test_random();
    test_async_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
